// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the GPU memory-side responder.
// WARP_ID_W fixes the warp id width carried inside the request/response structs.
package gpu_mem_pkg;

    localparam int          WORD_BYTES    = 4;
    localparam logic [31:0] ERR_READ_DATA = 32'hDEADBEEF;
    localparam int          WARP_ID_W     = 6;

    typedef struct packed {
        logic [31:0]          address;
        logic [31:0]          write_data;
        logic                 write_en;
        logic [WARP_ID_W-1:0] warp_id;
        logic [31:0]          thread_mask;
    } mem_req_t;

    typedef struct packed {
        logic [31:0]          read_data;
        logic [WARP_ID_W-1:0] warp_id;
        logic                 error;
    } mem_rsp_t;

    typedef struct packed {
        mem_rsp_t    rsp;
        logic [31:0] issue_time;
    } out_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/gpu_mem_outstanding_fifo.sv
// Synchronous FIFO of in-flight read entries; head is visible combinationally.
// Push while full and pop while empty are ignored.
module gpu_mem_outstanding_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/gpu_mem_responder.sv
// Memory-side responder: word array, fixed-latency in-order read responses
// with valid/ready backpressure, and saturating performance counters.
module gpu_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int MEMORY_LATENCY  = 100,
    parameter int MAX_OUTSTANDING = 8,
    parameter int WARP_ID_WIDTH   = WARP_ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_address,
    input  logic [31:0]              req_write_data,
    input  logic                     req_write_en,
    input  logic [WARP_ID_WIDTH-1:0] req_warp_id,
    input  logic [31:0]              req_thread_mask,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_read_data,
    output logic [WARP_ID_WIDTH-1:0] rsp_warp_id,
    output logic                     rsp_error,
    output logic [31:0]              perf_reads,
    output logic [31:0]              perf_writes,
    output logic [31:0]              perf_errors,
    output logic [31:0]              perf_stalls
);
    localparam int          AW      = $clog2(MEM_DEPTH_WORDS);
    localparam int          OFS     = $clog2(WORD_BYTES);
    localparam int          CW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [31:0] DUE_AGE = 32'(MEMORY_LATENCY - 1);

    logic [31:0] mem_array [MEM_DEPTH_WORDS];

    mem_req_t    req;
    out_entry_t  new_entry, head;
    logic [$bits(out_entry_t)-1:0] fifo_head;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0] fifo_count;
    logic        addr_err, accept, rd_accept, wr_accept, wr_commit;
    logic        rsp_free, head_due, bypass;
    logic [31:0] rd_word;

    logic        alive_q, alive_d;
    logic [31:0] now_q, now_d;
    logic        rsp_valid_q, rsp_valid_d;
    mem_rsp_t    rsp_q, rsp_d;
    logic [31:0] perf_reads_q, perf_reads_d, perf_writes_q, perf_writes_d;
    logic [31:0] perf_errors_q, perf_errors_d, perf_stalls_q, perf_stalls_d;

    assign req_ready = alive_q && !fifo_full;

    always_comb begin
        req = '{address: req_address, write_data: req_write_data, write_en: req_write_en,
                warp_id: req_warp_id, thread_mask: req_thread_mask};
        addr_err  = (req.address[OFS-1:0] != '0) ||
                    (req.address[31:OFS] >= (32-OFS)'(MEM_DEPTH_WORDS));
        accept    = req_valid && req_ready;
        rd_accept = accept && !req.write_en;
        wr_accept = accept && req.write_en;
        wr_commit = wr_accept && !addr_err && (req.thread_mask != '0);
        rd_word   = mem_array[req.address[AW+OFS-1:OFS]];

        new_entry.rsp.read_data = addr_err ? ERR_READ_DATA : rd_word;
        new_entry.rsp.warp_id   = req.warp_id;
        new_entry.rsp.error     = addr_err;
        new_entry.issue_time    = now_q;

        // Age is counted in edges since the accept edge; subtraction is wrap-safe.
        head     = out_entry_t'(fifo_head);
        head_due = !fifo_empty && ((now_q - head.issue_time) >= DUE_AGE);
        rsp_free = !rsp_valid_q || rsp_ready;
        // With a one-cycle latency the response must load on the accept edge itself.
        bypass    = (MEMORY_LATENCY == 1) && (fifo_count == '0) && rd_accept && rsp_free;
        fifo_push = rd_accept && !bypass;
        fifo_pop  = head_due && rsp_free;

        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        if (rsp_free) begin
            rsp_valid_d = fifo_pop || bypass;
            if (fifo_pop) begin
                rsp_d = head.rsp;
            end else if (bypass) begin
                rsp_d = new_entry.rsp;
            end
        end

        alive_d       = 1'b1;
        now_d         = now_q + 32'd1;
        perf_reads_d  = sat_inc(perf_reads_q, rd_accept);
        perf_writes_d = sat_inc(perf_writes_q, wr_accept);
        perf_errors_d = sat_inc(perf_errors_q, accept && addr_err);
        perf_stalls_d = sat_inc(perf_stalls_q, req_valid && !req_ready);
    end

    gpu_mem_outstanding_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(out_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (new_entry),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_array[req.address[AW+OFS-1:OFS]] <= req.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q       <= 1'b0;
            now_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_q         <= '0;
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_errors_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            alive_q       <= alive_d;
            now_q         <= now_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_q         <= rsp_d;
            perf_reads_q  <= perf_reads_d;
            perf_writes_q <= perf_writes_d;
            perf_errors_q <= perf_errors_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_q.read_data;
    assign rsp_warp_id   = rsp_q.warp_id;
    assign rsp_error     = rsp_q.error;
    assign perf_reads    = perf_reads_q;
    assign perf_writes   = perf_writes_q;
    assign perf_errors   = perf_errors_q;
    assign perf_stalls   = perf_stalls_q;

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Bench for gpu_mem_responder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gpu_mem_responder;
    localparam int LAT   = 20;
    localparam int MAXO  = 8;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_write_en = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_address = '0, req_write_data = '0, req_thread_mask = '0;
    logic [5:0]  req_warp_id = '0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_read_data, perf_reads, perf_writes, perf_errors, perf_stalls;
    logic [5:0]  rsp_warp_id;

    gpu_mem_responder #(
        .MEM_DEPTH_WORDS (DEPTH),
        .MEMORY_LATENCY  (LAT),
        .MAX_OUTSTANDING (MAXO),
        .WARP_ID_WIDTH   (6)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_address (req_address),
        .req_write_data (req_write_data), .req_write_en (req_write_en),
        .req_warp_id (req_warp_id), .req_thread_mask (req_thread_mask),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_read_data (rsp_read_data),
        .rsp_warp_id (rsp_warp_id), .rsp_error (rsp_error),
        .perf_reads (perf_reads), .perf_writes (perf_writes),
        .perf_errors (perf_errors), .perf_stalls (perf_stalls)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: pending reads with the edge at which each may enter the response slot.
    typedef struct {
        logic [31:0] data;
        logic [5:0]  warp;
        logic        err;
        int          due;
    } exp_t;

    exp_t        pend[$];
    logic [31:0] mem_m [int];
    logic        m_valid = 0, m_err = 0, m_alive = 0;
    logic [31:0] m_data = 0;
    logic [5:0]  m_warp = 0;
    logic [31:0] m_reads = 0, m_writes = 0, m_errors = 0, m_stalls = 0;

    function automatic logic [31:0] inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            m_valid = 0; m_data = 0; m_warp = 0; m_err = 0; m_alive = 0;
            m_reads = 0; m_writes = 0; m_errors = 0; m_stalls = 0;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_data", rsp_read_data, 32'd0);
            chk("rst_rsp_warp", 32'(rsp_warp_id), 32'd0);
            chk("rst_rsp_error", 32'(rsp_error), 32'd0);
            chk("rst_perf_reads", perf_reads, 32'd0);
            chk("rst_perf_writes", perf_writes, 32'd0);
            chk("rst_perf_errors", perf_errors, 32'd0);
            chk("rst_perf_stalls", perf_stalls, 32'd0);
        end else begin
            automatic logic m_ready = m_alive && (pend.size() < MAXO);
            automatic int   e = edge_cnt + 1;
            chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_rsp_data", rsp_read_data, m_data);
                chk("model_rsp_warp", 32'(rsp_warp_id), 32'(m_warp));
                chk("model_rsp_error", 32'(rsp_error), 32'(m_err));
            end
            chk("model_req_ready", 32'(req_ready), 32'(m_ready));
            chk("model_perf_reads", perf_reads, m_reads);
            chk("model_perf_writes", perf_writes, m_writes);
            chk("model_perf_errors", perf_errors, m_errors);
            chk("model_perf_stalls", perf_stalls, m_stalls);

            if (req_valid && !m_ready) m_stalls = inc(m_stalls);
            if (!m_valid || rsp_ready) begin
                if (pend.size() > 0 && pend[0].due <= e) begin
                    automatic exp_t p = pend.pop_front();
                    m_valid = 1; m_data = p.data; m_warp = p.warp; m_err = p.err;
                end else begin
                    m_valid = 0;
                end
            end
            if (req_valid && m_ready) begin
                automatic logic bad = (req_address[1:0] != 2'b00) || ((req_address >> 2) >= DEPTH);
                automatic int   idx = int'(req_address >> 2);
                if (bad) m_errors = inc(m_errors);
                if (req_write_en) begin
                    m_writes = inc(m_writes);
                    if (!bad && req_thread_mask != 0) mem_m[idx] = req_write_data;
                end else begin
                    automatic exp_t n;
                    m_reads = inc(m_reads);
                    n.data = bad ? 32'hDEADBEEF : (mem_m.exists(idx) ? mem_m[idx] : 32'h0);
                    n.warp = req_warp_id;
                    n.err  = bad;
                    n.due  = e + LAT - 1;
                    pend.push_back(n);
                end
            end
            m_alive = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request (leaves req_valid high) and returns the accept edge.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic we,
                        input logic [5:0] warp, input logic [31:0] mask, output int acc_e);
        automatic logic acc = 0;
        automatic int   guard = 0;
        req_address = addr; req_write_data = data; req_write_en = we;
        req_warp_id = warp; req_thread_mask = mask; req_valid = 1;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = req_ready;
            tick();
            guard++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        acc_e = edge_cnt;
    endtask

    task automatic idle();
        req_valid = 0;
    endtask

    // Returns at a negedge with rsp_valid high; e is the edge that first samples it.
    task automatic wait_rsp(output int e);
        automatic int g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        e = edge_cnt + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int acc_e [10];
    int t, e, tmp;
    logic [31:0] base;
    logic [31:0] d0;
    logic [5:0]  w0;
    int cnt;

    initial begin
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick(); tick();

        // 1: write then read, latency and contents
        send(32'h100, 32'hCAFEF00D, 1, 6'd3, 32'hFFFF_FFFF, tmp);
        send(32'h100, 32'h0, 0, 6'd5, 32'hFFFF_FFFF, t);
        idle();
        wait_rsp(e);
        chk("t1_latency", 32'(e - t), 32'(LAT));
        chk("t1_data", rsp_read_data, 32'hCAFEF00D);
        chk("t1_warp", 32'(rsp_warp_id), 32'd5);
        chk("t1_error", 32'(rsp_error), 32'd0);
        chk("t1_perf_reads", perf_reads, 32'd1);
        chk("t1_perf_writes", perf_writes, 32'd1);
        tick();

        // 2: ten back-to-back reads against an eight-deep queue
        for (int i = 0; i < 10; i++) send(32'h200 + 32'(4*i), 32'hA000_0000 + 32'(i), 1, 6'd0, 32'h1, tmp);
        idle();
        tick();
        @(negedge clk);
        base = perf_stalls;
        tick();
        fork
            begin
                for (int i = 0; i < 10; i++) send(32'h200 + 32'(4*i), 32'h0, 0, 6'(i), 32'h1, acc_e[i]);
                idle();
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    automatic int ee;
                    wait_rsp(ee);
                    chk("t2_order_warp", 32'(rsp_warp_id), 32'(i));
                    chk("t2_order_data", rsp_read_data, 32'hA000_0000 + 32'(i));
                    tick();
                end
            end
        join
        chk("t2_eighth_accept", 32'(acc_e[7] - acc_e[0]), 32'd7);
        chk("t2_ninth_accept", 32'(acc_e[8] - acc_e[0]), 32'(LAT));
        chk("t2_tenth_accept", 32'(acc_e[9] - acc_e[0]), 32'(LAT + 1));
        @(negedge clk);
        chk("t2_stalls", perf_stalls - base, 32'd12);
        tick();

        // 3: backpressure holds the response, then three drain on consecutive cycles
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) send(32'h200 + 32'(4*i), 32'h0, 0, 6'(10 + i), 32'h1, tmp);
        idle();
        wait_rsp(e);
        d0 = rsp_read_data; w0 = rsp_warp_id;
        chk("t3_first_warp", 32'(w0), 32'd10);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t3_hold_data", rsp_read_data, d0);
            chk("t3_hold_warp", 32'(rsp_warp_id), 32'(w0));
        end
        tick();
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_drain_valid", 32'(rsp_valid), 32'd1);
            chk("t3_drain_warp", 32'(rsp_warp_id), 32'(10 + i));
        end
        @(negedge clk);
        chk("t3_drained", 32'(rsp_valid), 32'd0);
        tick();

        // 4: misaligned read and out-of-range write
        send(32'h0, 32'h0BADF00D, 1, 6'd0, 32'hFFFF_FFFF, tmp);
        idle();
        @(negedge clk);
        base = perf_errors;
        tick();
        send(32'h102, 32'h0, 0, 6'd7, 32'h1, tmp);
        idle();
        wait_rsp(e);
        chk("t4_err_flag", 32'(rsp_error), 32'd1);
        chk("t4_err_data", rsp_read_data, 32'hDEADBEEF);
        chk("t4_err_warp", 32'(rsp_warp_id), 32'd7);
        tick();
        send(32'(DEPTH * 4), 32'h12345678, 1, 6'd0, 32'hFFFF_FFFF, tmp);
        send(32'h0, 32'h0, 0, 6'd8, 32'h1, tmp);
        idle();
        wait_rsp(e);
        chk("t4_alias_data", rsp_read_data, 32'h0BADF00D);
        chk("t4_alias_error", 32'(rsp_error), 32'd0);
        chk("t4_perf_errors", perf_errors - base, 32'd2);
        tick();

        // 5: read-before-write ordering and masked-off write
        send(32'h40, 32'h11111111, 1, 6'd0, 32'hFFFF_FFFF, tmp);
        send(32'h40, 32'h0, 0, 6'd1, 32'h1, t);
        send(32'h40, 32'h22222222, 1, 6'd0, 32'hFFFF_FFFF, tmp);
        idle();
        chk("t5_write_edge", 32'(tmp - t), 32'd1);
        wait_rsp(e);
        chk("t5_old_value", rsp_read_data, 32'h11111111);
        tick();
        send(32'h40, 32'h0, 0, 6'd2, 32'h1, tmp);
        idle();
        wait_rsp(e);
        chk("t5_new_value", rsp_read_data, 32'h22222222);
        tick();
        send(32'h40, 32'h33333333, 1, 6'd0, 32'h0, tmp);
        send(32'h40, 32'h0, 0, 6'd3, 32'h1, tmp);
        idle();
        wait_rsp(e);
        chk("t5_mask0_value", rsp_read_data, 32'h22222222);
        tick();

        // 6: reset with responses in flight
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) send(32'h40, 32'h0, 0, 6'(4 + i), 32'h1, tmp);
        idle();
        wait_rsp(e);
        tick();
        rst_n = 0;
        #1;
        chk("t6_async_valid", 32'(rsp_valid), 32'd0);
        chk("t6_async_reads", perf_reads, 32'd0);
        chk("t6_async_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rsp_ready = 1;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("t6_no_stale_rsp", 32'(cnt), 32'd0);
        tick();
        send(32'h40, 32'h0, 0, 6'd9, 32'h1, tmp);
        idle();
        wait_rsp(e);
        chk("t6_mem_kept", rsp_read_data, 32'h22222222);
        chk("t6_warp", 32'(rsp_warp_id), 32'd9);
        chk("t6_perf_reads", perf_reads, 32'd1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
